tiny_tpu_uart_top: RTL and testbench
====================================

// Module: tiny_tpu_uart_top
// PURPOSE
// Self-contained UART-controlled 2x2 int8 MLP engine; sits directly under the FPGA board wrapper (100 MHz clock).
// Host loads a 2x2 weight matrix and a 2-element input vector, runs 1..7 layers, and reads back 32-bit accumulators.
// Wide debug bus exposes FSM internals for LED display.
// PARAMETERS
// CLOCK_FREQ  100_000_000  clk frequency in Hz
// BAUD_RATE   115200       UART rate; bit period DIV = CLOCK_FREQ/BAUD_RATE (integer division)
// PORTS
// clk                     in  1   single clock, all logic rising-edge
// rst                     in  1   synchronous, active-high reset
// uart_rx                 in  1   8N1 serial in, idle high, async (2-FF synchronised)
// uart_tx                 out 1   8N1 serial out, idle high
// mlp_state_dbg           out 4   MLP FSM state code
// mlp_cycle_cnt_dbg       out 5   MAC cycle counter
// mlp_layer_dbg           out 3   current layer index (0-based)
// mlp_layer_complete_dbg  out 1   1-cycle pulse at end of each layer
// mlp_acc0_dbg            out 32  signed accumulator 0
// mlp_acc1_dbg            out 32  signed accumulator 1
// mlp_acc_valid_dbg       out 1   accumulators hold a finished result
// uart_state_dbg          out 4   command FSM state code
// uart_cmd_dbg            out 8   last command byte accepted
// uart_byte_count_dbg     out 3   payload bytes received for current command
// uart_resp_idx_dbg       out 2   index of response byte being sent
// uart_tx_valid_dbg       out 1   TX byte request
// uart_tx_ready_dbg       out 1   transmitter idle
// uart_rx_valid_dbg       out 1   1-cycle pulse per received byte
// uart_weights_ready_dbg  out 1   weight matrix loaded
// uart_start_mlp_dbg      out 1   1-cycle MLP start pulse
// BEHAVIOUR
// Reset: uart_tx=1, tx_ready=1, every other output, weights, inputs and accumulators = 0; both FSMs to code 0.
// RX: start edge, confirm low at DIV/2, sample 8 data bits LSB-first every DIV; stop bit 0 -> byte dropped; rx_valid pulses 1 cycle.
// TX: on tx_valid && tx_ready send start, 8 bits LSB-first, stop; each bit DIV cycles; tx_ready low while busy.
// Command FSM codes: 0 IDLE, 1 RX_PAYLOAD, 2 EXEC, 3 TX_BYTE, 4 TX_WAIT.
//  0x01 LOAD_W + 4 bytes w00,w01,w10,w11 (int8): store; weights_ready<=1.
//  0x02 LOAD_X + 2 bytes x0,x1 (int8): store; clears acc_valid.
//  0x03 RUN + 1 byte N: N=1..7 layers; start_mlp pulses only if weights_ready, MLP idle, N in 1..7; else ignored.
//  0x04 READ_ACC0 / 0x05 READ_ACC1: send 4 bytes of acc LSB first, resp_idx 0..3; no weights needed.
//  0x06 STATUS: send 1 byte {weights_ready, acc_valid, 2'b00, mlp_state}.
//  Any other byte: ignored, stays IDLE. No response to write commands.
//  byte_count resets to 0 on each command; EXEC lasts 1 cycle, then IDLE or TX_BYTE.
//  Bytes arriving during TX_BYTE/TX_WAIT are discarded.
// MLP FSM codes: 0 IDLE, 1 MAC, 2 ACT, 3 DONE.
//  start: clear accs, layer=0, acc_valid=0, -> MAC.
//  MAC: cycle_cnt 0..3 does acc0+=w00*x0, acc0+=w01*x1, acc1+=w10*x0, acc1+=w11*x1 (signed 16-bit products, sign-extended to 32).
//  ACT: layer_complete pulse. If layer<N-1: x_i <= clamp(acc_i,0,127) (ReLU + int8 saturate), clear accs, layer++, -> MAC.
//  Otherwise -> DONE.
//  DONE: acc_valid<=1, -> IDLE. Accumulators hold until next RUN or reset.
//  Layer latency: 4 MAC + 1 ACT cycles; cycle_cnt=0 outside MAC.
// Reset mid-frame/mid-run: everything aborts to reset values, a partially received byte is lost, uart_tx forced high immediately.
// TESTING
// Reset -> uart_tx=1, all debug outputs 0 except tx_ready=1; STATUS returns 0x00.
// LOAD_W 01 02 03 04, LOAD_X 05 06, RUN 01, READ_ACC0 -> 11 00 00 00; READ_ACC1 -> 27 00 00 00.
// LOAD_W FF 00 00 FF (-1,0,0,-1), LOAD_X 05 06, RUN 01 -> acc0=-5, READ_ACC0 -> FB FF FF FF.
// Same weights, RUN 02 -> layer 1 inputs clamp to 0; acc0=acc1=0; two layer_complete pulses.
// RUN before any LOAD_W -> no start pulse, STATUS bit7=0; unknown cmd 0x7E -> FSM stays IDLE.
// LOAD_W 7F 7F 7F 7F, LOAD_X 7F 7F, RUN 03 -> saturated inputs 127; acc0=acc1=32258 (0x00007E02).

Source files
------------

// File: rtl/tiny_tpu_uart_top.sv
// tiny_tpu_uart_top
// UART-controlled 2x2 int8 MLP engine. The host sends command bytes over an
// 8N1 link to load a weight matrix and an input vector, run 1..7 layers, and
// read back the two 32-bit signed accumulators or a status byte.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   uart_rx / uart_tx        8N1 serial in (asynchronous) / serial out, idle high
//   mlp_*_dbg                MLP FSM state, MAC cycle, layer, layer pulse,
//                            accumulators and result-valid flag
//   uart_*_dbg               command FSM state, last command, payload count,
//                            response index, TX handshake, RX pulse,
//                            weights-loaded flag, MLP start pulse
module tiny_tpu_uart_top #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [3:0]  mlp_state_dbg,
    output logic [4:0]  mlp_cycle_cnt_dbg,
    output logic [2:0]  mlp_layer_dbg,
    output logic        mlp_layer_complete_dbg,
    output logic [31:0] mlp_acc0_dbg,
    output logic [31:0] mlp_acc1_dbg,
    output logic        mlp_acc_valid_dbg,
    output logic [3:0]  uart_state_dbg,
    output logic [7:0]  uart_cmd_dbg,
    output logic [2:0]  uart_byte_count_dbg,
    output logic [1:0]  uart_resp_idx_dbg,
    output logic        uart_tx_valid_dbg,
    output logic        uart_tx_ready_dbg,
    output logic        uart_rx_valid_dbg,
    output logic        uart_weights_ready_dbg,
    output logic        uart_start_mlp_dbg
);

    localparam int DIV  = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);

    // ------------------------------------------------------------------
    // Receiver: bit 0 is the start-bit check at half a period, bits 1..8
    // are data (LSB first), bit 9 is the stop bit.
    // ------------------------------------------------------------------
    logic          rx_meta, rx_sync;
    logic          rx_busy;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_valid;
    logic [7:0]    rx_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_busy  <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_valid <= 1'b0;
            if (!rx_busy) begin
                if (!rx_sync) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_bit  <= '0;
                end
            end else if (rx_cnt == ((rx_bit == 4'd0) ? CW'(HALF - 1) : CW'(DIV - 1))) begin
                rx_cnt <= '0;
                if (rx_bit == 4'd0) begin
                    // glitch shorter than half a bit: not a real start
                    if (rx_sync) rx_busy <= 1'b0;
                    else         rx_bit  <= 4'd1;
                end else if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                    if (rx_sync) begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sh;
                    end
                end else begin
                    rx_sh  <= {rx_sync, rx_sh[7:1]};
                    rx_bit <= rx_bit + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmitter: start bit goes out on load, then 8 data bits and the
    // stop bit are shifted out of tx_sh, one per DIV cycles.
    // ------------------------------------------------------------------
    logic          tx_busy;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sh;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_byte;

    assign tx_ready = ~tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '1;
        end else if (!tx_busy) begin
            if (tx_valid) begin
                uart_tx <= 1'b0;
                tx_sh   <= {1'b1, tx_byte};
                tx_busy <= 1'b1;
                tx_cnt  <= '0;
                tx_bit  <= '0;
            end
        end else if (tx_cnt == CW'(DIV - 1)) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                uart_tx <= tx_sh[0];
                tx_sh   <= {1'b1, tx_sh[8:1]};
                tx_bit  <= tx_bit + 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        C_IDLE = 3'd0, C_RX_PAYLOAD = 3'd1, C_EXEC = 3'd2,
        C_TX_BYTE = 3'd3, C_TX_WAIT = 3'd4
    } cmd_state_t;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0, M_MAC = 2'd1, M_ACT = 2'd2, M_DONE = 2'd3
    } mlp_state_t;

    cmd_state_t       c_state, c_next;
    mlp_state_t       m_state, m_next;
    logic [7:0]       cmd;
    logic [2:0]       byte_count;
    logic [1:0]       resp_idx;
    logic [3:0][7:0]  pay;
    logic [3:0][7:0]  w;
    logic             weights_ready;
    logic [2:0]       run_n;
    logic             start_mlp, load_x;
    logic [2:0]       pay_len;
    logic [1:0]       resp_last;
    logic             rx_is_cmd;
    logic             n_ok;

    logic signed [31:0] acc0, acc1;
    logic signed [7:0]  x0, x1;
    logic [2:0]         layer;
    logic [4:0]         cycle_cnt;
    logic               acc_valid;
    logic [7:0]         status_byte;
    logic [31:0]        acc_sel;

    assign rx_is_cmd   = (rx_data >= 8'h01) && (rx_data <= 8'h06);
    assign pay_len     = (cmd == 8'h01) ? 3'd4 : (cmd == 8'h02) ? 3'd2 : 3'd1;
    assign resp_last   = (cmd == 8'h06) ? 2'd0 : 2'd3;
    assign n_ok        = (pay[0] >= 8'd1) && (pay[0] <= 8'd7);
    assign status_byte = {weights_ready, acc_valid, 2'b00, 2'b00, m_state};
    assign acc_sel     = (cmd == 8'h04) ? acc0 : acc1;

    always_ff @(posedge clk) begin
        if (rst) c_state <= C_IDLE;
        else     c_state <= c_next;
    end

    always_comb begin
        c_next    = c_state;
        tx_valid  = 1'b0;
        tx_byte   = 8'h00;
        start_mlp = 1'b0;
        load_x    = 1'b0;
        case (c_state)
            C_IDLE: begin
                if (rx_valid && rx_is_cmd)
                    c_next = (rx_data <= 8'h03) ? C_RX_PAYLOAD : C_EXEC;
            end
            C_RX_PAYLOAD: begin
                if (rx_valid && (byte_count == pay_len - 3'd1)) c_next = C_EXEC;
            end
            C_EXEC: begin
                load_x    = (cmd == 8'h02);
                start_mlp = (cmd == 8'h03) && weights_ready && (m_state == M_IDLE) && n_ok;
                c_next    = (cmd >= 8'h04) ? C_TX_BYTE : C_IDLE;
            end
            C_TX_BYTE: begin
                tx_valid = 1'b1;
                tx_byte  = (cmd == 8'h06) ? status_byte : acc_sel[resp_idx*8 +: 8];
                if (tx_ready) c_next = C_TX_WAIT;
            end
            C_TX_WAIT: begin
                // tx_ready drops the cycle after the handshake, so rising
                // ready here means the byte has fully left the wire
                if (tx_ready) c_next = (resp_idx == resp_last) ? C_IDLE : C_TX_BYTE;
            end
            default: c_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd           <= '0;
            byte_count    <= '0;
            resp_idx      <= '0;
            pay           <= '0;
            w             <= '0;
            weights_ready <= 1'b0;
            run_n         <= '0;
        end else begin
            case (c_state)
                C_IDLE: begin
                    if (rx_valid && rx_is_cmd) begin
                        cmd        <= rx_data;
                        byte_count <= '0;
                        resp_idx   <= '0;
                    end
                end
                C_RX_PAYLOAD: begin
                    if (rx_valid) begin
                        pay[byte_count[1:0]] <= rx_data;
                        byte_count           <= byte_count + 3'd1;
                    end
                end
                C_EXEC: begin
                    resp_idx <= '0;
                    if (cmd == 8'h01) begin
                        w             <= pay;
                        weights_ready <= 1'b1;
                    end
                    if (start_mlp) run_n <= pay[0][2:0];
                end
                C_TX_WAIT: begin
                    if (tx_ready && (resp_idx != resp_last)) resp_idx <= resp_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // MLP FSM and datapath
    // ------------------------------------------------------------------
    logic signed [7:0]  mac_w, mac_x;
    logic signed [15:0] prod;
    logic signed [31:0] prod_ext;
    logic               more_layers;

    function automatic logic [7:0] relu8(input logic signed [31:0] a);
        if (a < 0)             return 8'd0;
        else if (a > 32'sd127) return 8'd127;
        else                   return a[7:0];
    endfunction

    assign more_layers = (layer < run_n - 3'd1);

    always_comb begin
        case (cycle_cnt[1:0])
            2'd0:    begin mac_w = w[0]; mac_x = x0; end
            2'd1:    begin mac_w = w[1]; mac_x = x1; end
            2'd2:    begin mac_w = w[2]; mac_x = x0; end
            default: begin mac_w = w[3]; mac_x = x1; end
        endcase
        prod     = mac_w * mac_x;
        prod_ext = {{16{prod[15]}}, prod};
    end

    always_ff @(posedge clk) begin
        if (rst) m_state <= M_IDLE;
        else     m_state <= m_next;
    end

    always_comb begin
        m_next = m_state;
        case (m_state)
            M_IDLE: if (start_mlp) m_next = M_MAC;
            M_MAC:  if (cycle_cnt == 5'd3) m_next = M_ACT;
            M_ACT:  m_next = more_layers ? M_MAC : M_DONE;
            M_DONE: m_next = M_IDLE;
            default: m_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc0      <= '0;
            acc1      <= '0;
            x0        <= '0;
            x1        <= '0;
            layer     <= '0;
            cycle_cnt <= '0;
            acc_valid <= 1'b0;
        end else begin
            if (load_x) begin
                x0        <= pay[0];
                x1        <= pay[1];
                acc_valid <= 1'b0;
            end
            case (m_state)
                M_IDLE: begin
                    if (start_mlp) begin
                        acc0      <= '0;
                        acc1      <= '0;
                        layer     <= '0;
                        acc_valid <= 1'b0;
                    end
                end
                M_MAC: begin
                    if (cycle_cnt < 5'd2) acc0 <= acc0 + prod_ext;
                    else                  acc1 <= acc1 + prod_ext;
                    cycle_cnt <= (cycle_cnt == 5'd3) ? 5'd0 : cycle_cnt + 5'd1;
                end
                M_ACT: begin
                    if (more_layers) begin
                        x0    <= relu8(acc0);
                        x1    <= relu8(acc1);
                        acc0  <= '0;
                        acc1  <= '0;
                        layer <= layer + 3'd1;
                    end
                end
                M_DONE: acc_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Debug taps
    // ------------------------------------------------------------------
    assign mlp_state_dbg          = {2'b00, m_state};
    assign mlp_cycle_cnt_dbg      = cycle_cnt;
    assign mlp_layer_dbg          = layer;
    assign mlp_layer_complete_dbg = (m_state == M_ACT);
    assign mlp_acc0_dbg           = acc0;
    assign mlp_acc1_dbg           = acc1;
    assign mlp_acc_valid_dbg      = acc_valid;
    assign uart_state_dbg         = {1'b0, c_state};
    assign uart_cmd_dbg           = cmd;
    assign uart_byte_count_dbg    = byte_count;
    assign uart_resp_idx_dbg      = resp_idx;
    assign uart_tx_valid_dbg      = tx_valid;
    assign uart_tx_ready_dbg      = tx_ready;
    assign uart_rx_valid_dbg      = rx_valid;
    assign uart_weights_ready_dbg = weights_ready;
    assign uart_start_mlp_dbg     = start_mlp;

endmodule

// File: tb/tb_tiny_tpu_uart_top.sv
// Bench for tiny_tpu_uart_top: drives commands over uart_rx, decodes uart_tx
// bytes and compares them against an expected-byte queue filled when each
// read command is sent. Debug outputs are checked directly at quiet points.
module tb_tiny_tpu_uart_top;

    localparam int DIV = 10;   // 1 MHz / 100 kbaud

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic [3:0]  mlp_state_dbg;
    logic [4:0]  mlp_cycle_cnt_dbg;
    logic [2:0]  mlp_layer_dbg;
    logic        mlp_layer_complete_dbg;
    logic [31:0] mlp_acc0_dbg, mlp_acc1_dbg;
    logic        mlp_acc_valid_dbg;
    logic [3:0]  uart_state_dbg;
    logic [7:0]  uart_cmd_dbg;
    logic [2:0]  uart_byte_count_dbg;
    logic [1:0]  uart_resp_idx_dbg;
    logic        uart_tx_valid_dbg, uart_tx_ready_dbg, uart_rx_valid_dbg;
    logic        uart_weights_ready_dbg, uart_start_mlp_dbg;

    tiny_tpu_uart_top #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .mlp_state_dbg(mlp_state_dbg), .mlp_cycle_cnt_dbg(mlp_cycle_cnt_dbg),
        .mlp_layer_dbg(mlp_layer_dbg), .mlp_layer_complete_dbg(mlp_layer_complete_dbg),
        .mlp_acc0_dbg(mlp_acc0_dbg), .mlp_acc1_dbg(mlp_acc1_dbg),
        .mlp_acc_valid_dbg(mlp_acc_valid_dbg), .uart_state_dbg(uart_state_dbg),
        .uart_cmd_dbg(uart_cmd_dbg), .uart_byte_count_dbg(uart_byte_count_dbg),
        .uart_resp_idx_dbg(uart_resp_idx_dbg), .uart_tx_valid_dbg(uart_tx_valid_dbg),
        .uart_tx_ready_dbg(uart_tx_ready_dbg), .uart_rx_valid_dbg(uart_rx_valid_dbg),
        .uart_weights_ready_dbg(uart_weights_ready_dbg),
        .uart_start_mlp_dbg(uart_start_mlp_dbg)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int lc_cnt = 0;
    int st_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    always @(posedge clk) begin
        if (mlp_layer_complete_dbg) lc_cnt++;
        if (uart_start_mlp_dbg)     st_cnt++;
    end

    // TX decoder: mid-bit sampling, pops one expected byte per frame
    initial begin
        logic [7:0] got;
        forever begin
            @(negedge uart_tx);
            repeat (DIV/2) @(posedge clk);
            #1 chk("tx_start", {31'd0, uart_tx}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(posedge clk);
                #1 got[i] = uart_tx;
            end
            repeat (DIV) @(posedge clk);
            #1 chk("tx_stop", {31'd0, uart_tx}, 32'd1);
            if (exp_q.size() == 0) chk("tx_extra_byte", exp_q.size(), 32'd1);
            else                   chk("tx_byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic bit_out(input logic v);
        uart_rx = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain", exp_q.size(), 32'd0);
        idle(2*DIV);
    endtask

    task automatic read_acc(input logic [7:0] c, input logic [31:0] v);
        for (int i = 0; i < 4; i++) exp_q.push_back(v[i*8 +: 8]);
        send_byte(c);
        wait_drain();
    endtask

    task automatic read_status(input logic [7:0] v);
        exp_q.push_back(v);
        send_byte(8'h06);
        wait_drain();
    endtask

    task automatic load_w(input logic [7:0] a, b, c, d);
        send_byte(8'h01); send_byte(a); send_byte(b); send_byte(c); send_byte(d);
    endtask

    task automatic load_x(input logic [7:0] a, b);
        send_byte(8'h02); send_byte(a); send_byte(b);
    endtask

    task automatic run(input logic [7:0] n);
        send_byte(8'h03); send_byte(n);
        idle(60);
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx",      {31'd0, uart_tx}, 32'd1);
        chk("rst_txrdy",   {31'd0, uart_tx_ready_dbg}, 32'd1);
        chk("rst_mstate",  {28'd0, mlp_state_dbg}, 32'd0);
        chk("rst_ustate",  {28'd0, uart_state_dbg}, 32'd0);
        chk("rst_acc0",    mlp_acc0_dbg, 32'd0);
        chk("rst_acc1",    mlp_acc1_dbg, 32'd0);
        chk("rst_misc",    {mlp_cycle_cnt_dbg, mlp_layer_dbg, mlp_acc_valid_dbg,
                            uart_cmd_dbg, uart_byte_count_dbg, uart_resp_idx_dbg,
                            uart_tx_valid_dbg, uart_rx_valid_dbg,
                            uart_weights_ready_dbg, uart_start_mlp_dbg}, 32'd0);
        read_status(8'h00);

        // RUN without weights is ignored
        st_cnt = 0;
        run(8'h01);
        chk("run_no_w_start", st_cnt, 32'd0);
        read_status(8'h00);

        // unknown command
        send_byte(8'h7E);
        idle(5);
        chk("unk_state", {28'd0, uart_state_dbg}, 32'd0);
        chk("unk_cmd",   {24'd0, uart_cmd_dbg}, 32'h06);

        // basic single layer
        load_w(8'h01, 8'h02, 8'h03, 8'h04);
        load_x(8'h05, 8'h06);
        st_cnt = 0;
        run(8'h01);
        chk("start_pulse", st_cnt, 32'd1);
        chk("wready",   {31'd0, uart_weights_ready_dbg}, 32'd1);
        chk("accvalid", {31'd0, mlp_acc_valid_dbg}, 32'd1);
        read_acc(8'h04, 32'h0000_0011);
        read_acc(8'h05, 32'h0000_0027);
        read_status(8'hC0);

        // negative weights
        load_w(8'hFF, 8'h00, 8'h00, 8'hFF);
        load_x(8'h05, 8'h06);
        idle(5);
        chk("loadx_clr_valid", {31'd0, mlp_acc_valid_dbg}, 32'd0);
        run(8'h01);
        chk("neg_acc1", mlp_acc1_dbg, 32'hFFFF_FFFA);
        read_acc(8'h04, 32'hFFFF_FFFB);

        // two layers: ReLU clamps layer-1 inputs to zero
        lc_cnt = 0;
        run(8'h02);
        chk("lc2", lc_cnt, 32'd2);
        chk("relu_acc0", mlp_acc0_dbg, 32'd0);
        chk("layer2", {29'd0, mlp_layer_dbg}, 32'd1);
        read_acc(8'h05, 32'h0000_0000);

        // saturation over three layers
        load_w(8'h7F, 8'h7F, 8'h7F, 8'h7F);
        load_x(8'h7F, 8'h7F);
        lc_cnt = 0;
        run(8'h03);
        chk("lc3", lc_cnt, 32'd3);
        read_acc(8'h04, 32'h0000_7E02);
        read_acc(8'h05, 32'h0000_7E02);

        // out-of-range layer counts
        st_cnt = 0;
        run(8'h08);
        run(8'h00);
        chk("run_bad_n", st_cnt, 32'd0);

        // reset in the middle of an incoming frame
        @(posedge clk); #1;
        uart_rx = 1'b0;
        idle(3*DIV);
        rst = 1'b1;
        idle(2);
        uart_rx = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2*DIV);
        chk("mid_rst_ustate", {28'd0, uart_state_dbg}, 32'd0);
        chk("mid_rst_wready", {31'd0, uart_weights_ready_dbg}, 32'd0);
        chk("mid_rst_acc0",   mlp_acc0_dbg, 32'd0);
        read_status(8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
